// File: rtl/mem_pipe.sv
// Multi-cycle request/response memory for the WISC CPU.
// Reads travel through a fixed-latency delay line; writes commit at accept.
module mem_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4,
  parameter int PIPELINED  = 0,
  parameter int BYTE_ADDR  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  input  logic                  flush,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  busy
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept;
  logic                  rd_acc;
  logic                  wr_acc;

  logic [LATENCY-1:0]                 v_q;
  logic [LATENCY-1:0][ADDR_WIDTH-1:0] a_q;
  logic [LATENCY-1:0][DATA_WIDTH-1:0] d_q;

  generate
    if (BYTE_ADDR != 0) begin : g_byte
      assign idx = req_addr[DEPTH_LOG2:1];
    end else begin : g_word
      assign idx = req_addr[DEPTH_LOG2-1:0];
    end
  endgenerate

  // req_ready already folds in flush, so nothing is accepted in a flush cycle
  assign accept = req_valid & req_ready;
  assign rd_acc = accept & ~req_wr;
  assign wr_acc = accept & req_wr;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[idx] <= req_wdata;
    end
  end

  // Stage payload only moves with a valid entry, so the output stage holds
  // its last response while rsp_valid is low (including across a flush).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      a_q <= '0;
      d_q <= '0;
    end else begin
      v_q[0] <= rd_acc;
      if (rd_acc) begin
        a_q[0] <= req_addr;
        d_q[0] <= mem[idx];
      end
      for (int i = 1; i < LATENCY; i++) begin
        v_q[i] <= v_q[i-1] & ~flush;
        if (v_q[i-1] && !flush) begin
          a_q[i] <= a_q[i-1];
          d_q[i] <= d_q[i-1];
        end
      end
    end
  end

  assign rsp_valid = v_q[LATENCY-1];
  assign rsp_data  = d_q[LATENCY-1];
  assign rsp_addr  = a_q[LATENCY-1];

  generate
    if (PIPELINED != 0) begin : g_pipe
      assign req_ready = ~flush;
      assign busy      = (|v_q) | wr_acc;
    end else begin : g_block
      logic [3:0] cnt_q;

      // Counter reaches zero in the response cycle, allowing back-to-back accepts
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else if (flush) begin
          cnt_q <= '0;
        end else if (accept) begin
          cnt_q <= 4'(LATENCY - 1);
        end else if (cnt_q != '0) begin
          cnt_q <= cnt_q - 4'd1;
        end
      end

      assign busy      = (cnt_q != '0);
      assign req_ready = ~busy & ~flush;
    end
  endgenerate

endmodule
